// File: rtl/hazard_stall_controller.sv
// Pipeline stall/flush controller: load-use, ID-branch operand and mult/div occupancy hazards.
// Mealy stall outputs, with a state register and a down-counter for multi-cycle stalls.
module hazard_stall_controller #(
    parameter int unsigned MULDIV_CYCLES = 4,
    parameter int unsigned CNT_W         = 3
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [31:0] ID_Instruction,
    input  logic        ID_BranchTaken,
    input  logic [4:0]  EX_RegisterRd,
    input  logic        EX_RegWrite,
    input  logic        EX_MemRead,
    input  logic        EX_MulDivStart,
    input  logic [4:0]  MEM_RegisterRd,
    input  logic        MEM_MemRead,
    output logic        PCWrite,
    output logic        IF_ID_Write,
    output logic        ID_EX_Write,
    output logic        ID_EX_Bubble,
    output logic        EX_MEM_Bubble,
    output logic        IF_ID_Flush,
    output logic [1:0]  HazardState
);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        STALL  = 2'b01,
        MULDIV = 2'b10
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] count;

    logic [5:0] op;
    logic [5:0] funct;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       rs_used;
    logic       rt_used;
    logic       is_branch;
    logic       is_jump;
    logic       ex_hit_rs;
    logic       ex_hit_rt;
    logic       mem_hit;
    logic       load_use;
    logic       branch_ex;
    logic       branch_mem;
    logic       need_one;
    logic       need_two;
    logic       unused_bits;

    assign op    = ID_Instruction[31:26];
    assign rs    = ID_Instruction[25:21];
    assign rt    = ID_Instruction[20:16];
    assign funct = ID_Instruction[5:0];

    // Immediate/rd/shamt fields never take part in hazard detection.
    assign unused_bits = ^ID_Instruction[15:6];

    assign is_branch = (op == 6'b000100) || (op == 6'b000101);
    assign is_jump   = (op == 6'b000010) || (op == 6'b000011);

    assign rs_used = !(is_jump || (op == 6'b001111) ||
                       ((op == 6'b000000) &&
                        ((funct == 6'b000000) || (funct == 6'b000010) || (funct == 6'b000011))));

    assign rt_used = (op == 6'b000000) || is_branch ||
                     (op == 6'b101011) || (op == 6'b101000) || (op == 6'b101001);

    assign ex_hit_rs = (EX_RegisterRd != 5'd0) && (EX_RegisterRd == rs);
    assign ex_hit_rt = (EX_RegisterRd != 5'd0) && (EX_RegisterRd == rt);
    assign mem_hit   = (MEM_RegisterRd != 5'd0) &&
                       ((MEM_RegisterRd == rs) || (MEM_RegisterRd == rt));

    assign load_use   = EX_MemRead && ((rs_used && ex_hit_rs) || (rt_used && ex_hit_rt));
    assign branch_ex  = is_branch && EX_RegWrite && (ex_hit_rs || ex_hit_rt);
    assign branch_mem = is_branch && MEM_MemRead && mem_hit;

    // A branch waiting on a load still in EX needs the value to reach MEM first.
    assign need_two = branch_ex && EX_MemRead;
    assign need_one = load_use || branch_ex || branch_mem;

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state <= IDLE;
            count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (EX_MulDivStart) begin
                        state <= MULDIV;
                        count <= CNT_W'(MULDIV_CYCLES - 1);
                    end else if (need_two) begin
                        state <= STALL;
                        count <= CNT_W'(1);
                    end
                end
                STALL, MULDIV: begin
                    if (count == CNT_W'(1)) begin
                        state <= IDLE;
                        count <= '0;
                    end else begin
                        count <= count - CNT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    count <= '0;
                end
            endcase
        end
    end

    always_comb begin
        PCWrite       = 1'b1;
        IF_ID_Write   = 1'b1;
        ID_EX_Write   = 1'b1;
        ID_EX_Bubble  = 1'b0;
        EX_MEM_Bubble = 1'b0;
        IF_ID_Flush   = 1'b0;
        if (Reset) begin
            case (state)
                IDLE: begin
                    if (EX_MulDivStart) begin
                        PCWrite       = 1'b0;
                        IF_ID_Write   = 1'b0;
                        ID_EX_Write   = 1'b0;
                        EX_MEM_Bubble = 1'b1;
                    end else if (need_one) begin
                        PCWrite      = 1'b0;
                        IF_ID_Write  = 1'b0;
                        ID_EX_Bubble = 1'b1;
                    end else if (is_jump || (is_branch && ID_BranchTaken)) begin
                        IF_ID_Flush = 1'b1;
                    end
                end
                STALL: begin
                    PCWrite      = 1'b0;
                    IF_ID_Write  = 1'b0;
                    ID_EX_Bubble = 1'b1;
                end
                MULDIV: begin
                    PCWrite       = 1'b0;
                    IF_ID_Write   = 1'b0;
                    ID_EX_Write   = 1'b0;
                    EX_MEM_Bubble = 1'b1;
                end
                default: begin
                    PCWrite = 1'b1;
                end
            endcase
        end
    end

    assign HazardState = Reset ? state : 2'b00;

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Directed bench for hazard_stall_controller: each scenario drives vectors and checks
// the packed output word against hand-derived values.
module tb_hazard_stall_controller;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [31:0] ID_Instruction;
    logic        ID_BranchTaken;
    logic [4:0]  EX_RegisterRd;
    logic        EX_RegWrite;
    logic        EX_MemRead;
    logic        EX_MulDivStart;
    logic [4:0]  MEM_RegisterRd;
    logic        MEM_MemRead;
    logic        PCWrite;
    logic        IF_ID_Write;
    logic        ID_EX_Write;
    logic        ID_EX_Bubble;
    logic        EX_MEM_Bubble;
    logic        IF_ID_Flush;
    logic [1:0]  HazardState;

    int checks = 0;
    int errors = 0;

    // {PCWrite, IF_ID_Write, ID_EX_Write, ID_EX_Bubble, EX_MEM_Bubble, IF_ID_Flush, HazardState}
    logic [7:0] outs;
    assign outs = {PCWrite, IF_ID_Write, ID_EX_Write, ID_EX_Bubble,
                   EX_MEM_Bubble, IF_ID_Flush, HazardState};

    localparam logic [7:0] RUN     = 8'b111_000_00;
    localparam logic [7:0] STALL_I = 8'b001_100_00;
    localparam logic [7:0] STALL_S = 8'b001_100_01;
    localparam logic [7:0] FLUSH   = 8'b111_001_00;
    localparam logic [7:0] MD_I    = 8'b000_010_00;
    localparam logic [7:0] MD_S    = 8'b000_010_10;

    localparam logic [31:0] NOP       = 32'h0000_0000;
    localparam logic [31:0] ADD_9_8_10 = {6'b000000, 5'd8, 5'd10, 5'd9, 5'd0, 6'b100000};
    localparam logic [31:0] BEQ_9_0   = {6'b000100, 5'd9, 5'd0, 16'h0004};
    localparam logic [31:0] BNE_5_6   = {6'b000101, 5'd5, 5'd6, 16'h0008};
    localparam logic [31:0] SW_8      = {6'b101011, 5'd29, 5'd8, 16'h0010};
    localparam logic [31:0] SLL_RS8   = {6'b000000, 5'd8, 5'd2, 5'd1, 5'd4, 6'b000000};
    localparam logic [31:0] J_RS8     = {6'b000010, 26'h100_0000};

    hazard_stall_controller #(
        .MULDIV_CYCLES(4),
        .CNT_W(3)
    ) dut (
        .Clk(Clk),
        .Reset(Reset),
        .ID_Instruction(ID_Instruction),
        .ID_BranchTaken(ID_BranchTaken),
        .EX_RegisterRd(EX_RegisterRd),
        .EX_RegWrite(EX_RegWrite),
        .EX_MemRead(EX_MemRead),
        .EX_MulDivStart(EX_MulDivStart),
        .MEM_RegisterRd(MEM_RegisterRd),
        .MEM_MemRead(MEM_MemRead),
        .PCWrite(PCWrite),
        .IF_ID_Write(IF_ID_Write),
        .ID_EX_Write(ID_EX_Write),
        .ID_EX_Bubble(ID_EX_Bubble),
        .EX_MEM_Bubble(EX_MEM_Bubble),
        .IF_ID_Flush(IF_ID_Flush),
        .HazardState(HazardState)
    );

    always #5 Clk = ~Clk;

    // Inputs change on the falling edge; outputs are sampled 2 time units later,
    // well before the next rising edge.
    task automatic drive(input logic rst, input logic [31:0] instr, input logic taken,
                         input logic [4:0] exrd, input logic exrw, input logic exmr,
                         input logic mds, input logic [4:0] memrd, input logic memmr);
        @(negedge Clk);
        Reset          = rst;
        ID_Instruction = instr;
        ID_BranchTaken = taken;
        EX_RegisterRd  = exrd;
        EX_RegWrite    = exrw;
        EX_MemRead     = exmr;
        EX_MulDivStart = mds;
        MEM_RegisterRd = memrd;
        MEM_MemRead    = memmr;
        #2;
    endtask

    task automatic test_reset;
        drive(1'b0, ADD_9_8_10, 1'b0, 5'd8, 1'b1, 1'b1, 1'b1, 5'd0, 1'b0);
        checks++; if (outs !== RUN) begin errors++; $display("FAIL reset_pre_edge got %b exp %b", outs, RUN); end
        drive(1'b0, ADD_9_8_10, 1'b0, 5'd8, 1'b1, 1'b1, 1'b1, 5'd0, 1'b0);
        checks++; if (outs !== RUN) begin errors++; $display("FAIL reset_held got %b exp %b", outs, RUN); end
        drive(1'b1, NOP, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
        checks++; if (outs !== RUN) begin errors++; $display("FAIL reset_idle got %b exp %b", outs, RUN); end
    endtask

    task automatic test_load_use;
        drive(1'b1, ADD_9_8_10, 1'b0, 5'd8, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0);
        checks++; if (outs !== STALL_I) begin errors++; $display("FAIL load_use_stall got %b exp %b", outs, STALL_I); end
        drive(1'b1, ADD_9_8_10, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd8, 1'b1);
        checks++; if (outs !== RUN) begin errors++; $display("FAIL load_use_release got %b exp %b", outs, RUN); end
        drive(1'b1, SW_8, 1'b0, 5'd8, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0);
        checks++; if (outs !== STALL_I) begin errors++; $display("FAIL load_use_sw_rt got %b exp %b", outs, STALL_I); end
        drive(1'b1, SLL_RS8, 1'b0, 5'd8, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0);
        checks++; if (outs !== RUN) begin errors++; $display("FAIL load_use_sll_rs got %b exp %b", outs, RUN); end
    endtask

    task automatic test_branch_load;
        drive(1'b1, BEQ_9_0, 1'b0, 5'd9, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0);
        checks++; if (outs !== STALL_I) begin errors++; $display("FAIL br_load_c1 got %b exp %b", outs, STALL_I); end
        drive(1'b1, BEQ_9_0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd9, 1'b1);
        checks++; if (outs !== STALL_S) begin errors++; $display("FAIL br_load_c2 got %b exp %b", outs, STALL_S); end
        drive(1'b1, BEQ_9_0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
        checks++; if (outs !== RUN) begin errors++; $display("FAIL br_load_done got %b exp %b", outs, RUN); end
        drive(1'b1, BEQ_9_0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0);
        checks++; if (outs !== RUN) begin errors++; $display("FAIL br_load_rd0 got %b exp %b", outs, RUN); end
        drive(1'b1, BEQ_9_0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd9, 1'b1);
        checks++; if (outs !== STALL_I) begin errors++; $display("FAIL br_mem_stall got %b exp %b", outs, STALL_I); end
        drive(1'b1, BEQ_9_0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
        checks++; if (outs !== RUN) begin errors++; $display("FAIL br_mem_done got %b exp %b", outs, RUN); end
    endtask

    task automatic test_branch_alu;
        drive(1'b1, BNE_5_6, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0);
        checks++; if (outs !== STALL_I) begin errors++; $display("FAIL br_alu_stall got %b exp %b", outs, STALL_I); end
        drive(1'b1, BNE_5_6, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
        checks++; if (outs !== FLUSH) begin errors++; $display("FAIL br_alu_flush got %b exp %b", outs, FLUSH); end
        drive(1'b1, NOP, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
        checks++; if (outs !== RUN) begin errors++; $display("FAIL br_alu_after got %b exp %b", outs, RUN); end
        drive(1'b1, J_RS8, 1'b0, 5'd8, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0);
        checks++; if (outs !== FLUSH) begin errors++; $display("FAIL jump_flush got %b exp %b", outs, FLUSH); end
    endtask

    task automatic test_muldiv;
        drive(1'b1, NOP, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0);
        checks++; if (outs !== MD_I) begin errors++; $display("FAIL muldiv_c1 got %b exp %b", outs, MD_I); end
        drive(1'b1, NOP, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
        checks++; if (outs !== MD_S) begin errors++; $display("FAIL muldiv_c2 got %b exp %b", outs, MD_S); end
        drive(1'b1, NOP, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0);
        checks++; if (outs !== MD_S) begin errors++; $display("FAIL muldiv_c3 got %b exp %b", outs, MD_S); end
        drive(1'b1, NOP, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
        checks++; if (outs !== MD_S) begin errors++; $display("FAIL muldiv_c4 got %b exp %b", outs, MD_S); end
        drive(1'b1, NOP, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
        checks++; if (outs !== RUN) begin errors++; $display("FAIL muldiv_done got %b exp %b", outs, RUN); end
    endtask

    task automatic test_priority;
        drive(1'b1, ADD_9_8_10, 1'b0, 5'd8, 1'b1, 1'b1, 1'b1, 5'd0, 1'b0);
        checks++; if (outs !== MD_I) begin errors++; $display("FAIL prio_md_over_load got %b exp %b", outs, MD_I); end
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, NOP, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
            checks++; if (outs !== MD_S) begin errors++; $display("FAIL prio_md_cycle%0d got %b exp %b", i, outs, MD_S); end
        end
        drive(1'b1, BNE_5_6, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0);
        checks++; if (outs !== STALL_I) begin errors++; $display("FAIL prio_stall_over_flush got %b exp %b", outs, STALL_I); end
    endtask

    task automatic test_reset_mid;
        drive(1'b1, NOP, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0);
        checks++; if (outs !== MD_I) begin errors++; $display("FAIL rst_md_start got %b exp %b", outs, MD_I); end
        drive(1'b0, NOP, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
        checks++; if (outs !== RUN) begin errors++; $display("FAIL rst_md_asserted got %b exp %b", outs, RUN); end
        drive(1'b1, NOP, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
        checks++; if (outs !== RUN) begin errors++; $display("FAIL rst_md_after got %b exp %b", outs, RUN); end
        drive(1'b1, BEQ_9_0, 1'b0, 5'd9, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0);
        checks++; if (outs !== STALL_I) begin errors++; $display("FAIL rst_st_start got %b exp %b", outs, STALL_I); end
        drive(1'b0, NOP, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
        checks++; if (outs !== RUN) begin errors++; $display("FAIL rst_st_asserted got %b exp %b", outs, RUN); end
        drive(1'b1, NOP, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
        checks++; if (outs !== RUN) begin errors++; $display("FAIL rst_st_after got %b exp %b", outs, RUN); end
    endtask

    initial begin
        Reset          = 1'b0;
        ID_Instruction = NOP;
        ID_BranchTaken = 1'b0;
        EX_RegisterRd  = 5'd0;
        EX_RegWrite    = 1'b0;
        EX_MemRead     = 1'b0;
        EX_MulDivStart = 1'b0;
        MEM_RegisterRd = 5'd0;
        MEM_MemRead    = 1'b0;
        test_reset;
        test_load_use;
        test_branch_load;
        test_branch_alu;
        test_muldiv;
        test_priority;
        test_reset_mid;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
